uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
Transmit-side consumer of the baud rate divider output. Converts `baudSignalIn` (a square wave whose period equals one bit time) into per-bit ticks. Accepts bytes through a valid/ready handshake into a 1-entry holding register, then serializes each byte as a UART frame on `txOut`. Frames are LSB first: start bit, 5–8 data bits, optional parity, then 1 or 2 stop bits. Sits between the TX data path (register or FIFO) and the pad.

Parameters:
- IDLE_LEVEL, 1, level driven on `txOut` when not transmitting and during stop bits.

Ports:
- `clock` — input, 1 — system clock; same domain as the baud rate divider.
- `reset` — input, 1 — asynchronous, active-high reset.
- `enable` — input, 1 — block enable; same polarity as the divider enable.
- `baudSignalIn` — input, 1 — square wave from the divider; each rising edge marks one bit boundary.
- `txData` — input, 8 — byte to send.
- `txValid` — input, 1 — `txData` is valid.
- `txReady` — output, 1 — holding register can accept a byte.
- `wordLength` — input, 2 — data width: 00=5, 01=6, 10=7, 11=8 bits.
- `parityEnable` — input, 1 — insert a parity bit.
- `evenParity` — input, 1 — 1 = even parity, 0 = odd parity.
- `twoStopBits` — input, 1 — 1 = two stop bits, 0 = one stop bit.
- `breakCtrl` — input, 1 — force `txOut` low.
- `txOut` — output, 1 — serial line.
- `busy` — output, 1 — a frame is in progress or the holding register is full.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; `holdFull` = 0; `baudPrev` = 0; `baudTick` = 0; bit counter = 0.
  - `txOut` = IDLE_LEVEL; `txReady` = 0 while `reset` is high; `busy` = 0.
- Tick generation:
  - `baudPrev` registers `baudSignalIn`.
  - `baudTick` is a registered pulse, high for exactly 1 clock in the cycle after `baudSignalIn` is sampled 1 while `baudPrev` is 0.
  - No synchronizer: same clock domain.
- Handshake:
  - `txReady = enable & ~holdFull & ~reset` (combinational).
  - A transfer occurs on a clock edge where `txValid & txReady`. It latches `txData` into the holding register and sets `holdFull`.
  - `txData` may change freely after the transfer.
- State machine (advances only on `baudTick`; holds otherwise):
  - IDLE: if `holdFull & enable`, go to START. Copy hold to the shift register, clear `holdFull`, and latch `wordLength`, `parityEnable`, `evenParity`, `twoStopBits` for the whole frame.
  - START: `txOut` = 0. Next tick goes to DATA with bit counter = 0.
  - DATA: `txOut = shift[0]`; shift right on each tick.
    - After the bit with counter = `wordLength` + 4, go to PARITY if parity is enabled, else STOP1.
  - PARITY: `txOut` = XOR of the transmitted data bits only, inverted when `evenParity` = 0. Next tick goes to STOP1.
  - STOP1: `txOut` = IDLE_LEVEL. Next tick goes to STOP2 if `twoStopBits`, else IDLE.
  - STOP2: `txOut` = IDLE_LEVEL. Next tick goes to IDLE.
- Line timing:
  - `txOut` is registered and changes in the same cycle the state changes, i.e. 2 clocks after the `baudSignalIn` rising edge.
  - Every bit lasts exactly one `baudSignalIn` period.
- Back-to-back frames: a byte held when the frame's last stop-bit tick arrives gives IDLE → START on the very next tick. No extra idle bit is inserted.
- Latency: accept to start-bit edge is between 1 and one full bit period plus 2 clocks.
- `busy` = `holdFull` | (state ≠ IDLE), registered-equivalent (derived from registers only).
- `breakCtrl` = 1: `txOut` is forced to 0 combinationally after the output register. The state machine keeps running, so a frame in flight is corrupted by design.
- `enable` = 0:
  - `txReady` = 0.
  - A frame in progress completes.
  - IDLE does not start a new frame; the held byte is retained.
- Reset mid-frame: `txOut` returns to IDLE_LEVEL immediately and the held byte is discarded.
- Config inputs changed mid-frame take effect from the next START only.
- `baudSignalIn` stuck (divider disabled): the state machine freezes and `txOut` holds its current bit.

Test Plan:
- 8N1, send 0xA5 with a slow baud wave (period 32 clocks):
  - `txOut` = 0, then 1,0,1,0,0,1,0,1, then 1, each 32 clocks long.
  - `busy` drops at the IDLE return; `txReady` rises the cycle after the accept clears `holdFull`.
- 7E2, send 0x35: start, then 1,0,1,0,1,1,0, parity 0, two stop bits of 1. Bit 7 of the input is ignored.
- 5O1, send 0x1F: start, then 1,1,1,1,1, parity 0, stop 1. Repeat with `evenParity` = 1 → parity 1.
- Back-to-back 0x55 then 0xAA with `txValid` held high: the second start bit begins on the tick immediately after the first stop bit, with no idle gap.
- `breakCtrl` pulsed mid-DATA: `txOut` is 0 during the pulse, and the frame ends on schedule. Separately, deassert `enable` mid-frame: the frame completes and the held byte is not sent until `enable` = 1.
- Assert `reset` during PARITY: `txOut` = 1 and `busy` = 0 asynchronously. After release, 0x3C sends correctly.

Source files
------------

// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer_if
// Purpose  : Byte valid/ready handshake between the TX data path and the
//            UART serializer.
// Revision : 1.0
// ============================================================================
interface uart_tx_serializer_if;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;

  modport master (output txData, output txValid, input txReady);
  modport slave  (input txData, input txValid, output txReady);
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Purpose  : 1-entry holding register plus UART frame serializer. It is
//            paced by rising edges of the divider's baud square wave.
// Revision : 1.0
// ============================================================================
module uart_tx_serializer #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  wire logic               clock,
  input  wire logic               reset,
  input  wire logic               enable,
  input  wire logic               baudSignalIn,
  uart_tx_serializer_if.slave     tx_if,
  input  wire logic [1:0]         wordLength,
  input  wire logic               parityEnable,
  input  wire logic               evenParity,
  input  wire logic               twoStopBits,
  input  wire logic               breakCtrl,
  output logic                    txOut,
  output logic                    busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP1  = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;

  logic [2:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_full_q, hold_full_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] wlen_q, wlen_d;
  logic       par_en_q, par_en_d;
  logic       two_stop_q, two_stop_d;
  logic       parity_q, parity_d;
  logic       baud_prev_q, baud_prev_d;
  logic       baud_tick_q, baud_tick_d;
  logic       tx_out_q, tx_out_d;

  logic       w_load;
  logic [7:0] w_mask;
  logic [2:0] w_last_bit;

  assign tx_if.txReady = enable & ~hold_full_q & ~reset;
  assign busy          = hold_full_q | (state_q != ST_IDLE);
  assign txOut         = breakCtrl ? 1'b0 : tx_out_q;

  assign w_mask     = 8'hFF >> (2'd3 - wordLength);
  assign w_last_bit = {1'b0, wlen_q} + 3'd4;

  // State register and all datapath flops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= 8'h00;
      hold_data_q <= 8'h00;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      wlen_q      <= 2'd0;
      par_en_q    <= 1'b0;
      two_stop_q  <= 1'b0;
      parity_q    <= 1'b0;
      baud_prev_q <= 1'b0;
      baud_tick_q <= 1'b0;
      tx_out_q    <= IDLE_LEVEL;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      wlen_q      <= wlen_d;
      par_en_q    <= par_en_d;
      two_stop_q  <= two_stop_d;
      parity_q    <= parity_d;
      baud_prev_q <= baud_prev_d;
      baud_tick_q <= baud_tick_d;
      tx_out_q    <= tx_out_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    wlen_d      = wlen_q;
    par_en_d    = par_en_q;
    two_stop_d  = two_stop_q;
    parity_d    = parity_q;
    baud_prev_d = baudSignalIn;
    baud_tick_d = baudSignalIn & ~baud_prev_q;
    w_load      = 1'b0;

    if (tx_if.txValid && tx_if.txReady) begin
      hold_data_d = tx_if.txData;
      hold_full_d = 1'b1;
    end

    if (baud_tick_q) begin
      case (state_q)
        ST_IDLE:   w_load = hold_full_q & enable;
        ST_START: begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
        ST_DATA: begin
          if (bit_cnt_q == w_last_bit) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
        ST_PARITY: state_d = ST_STOP1;
        ST_STOP1: begin
          state_d = two_stop_q ? ST_STOP2 : ST_IDLE;
          w_load  = ~two_stop_q & hold_full_q & enable;
        end
        ST_STOP2: begin
          state_d = ST_IDLE;
          w_load  = hold_full_q & enable;
        end
        default:   state_d = ST_IDLE;
      endcase

      // Loading straight from the last stop bit avoids an idle bit between frames
      if (w_load) begin
        state_d     = ST_START;
        shift_d     = hold_data_q;
        hold_full_d = 1'b0;
        wlen_d      = wordLength;
        par_en_d    = parityEnable;
        two_stop_d  = twoStopBits;
        parity_d    = (^(hold_data_q & w_mask)) ^ ~evenParity;
      end
    end
  end

  // Line level follows the next state so it changes with the state register
  always_comb begin
    tx_out_d = IDLE_LEVEL;
    case (state_d)
      ST_START:  tx_out_d = 1'b0;
      ST_DATA:   tx_out_d = shift_d[0];
      ST_PARITY: tx_out_d = parity_d;
      default:   tx_out_d = IDLE_LEVEL;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_serializer
// Purpose  : Directed and randomized frame checks of uart_tx_serializer
//            against a bit-list model of a UART frame.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       baudSignalIn = 1'b0;
  logic [1:0] wordLength = 2'd3;
  logic       parityEnable = 1'b0;
  logic       evenParity = 1'b0;
  logic       twoStopBits = 1'b0;
  logic       breakCtrl = 1'b0;
  logic       txOut;
  logic       busy;

  int baud_half = 16;
  int baud_cnt  = 0;
  int checks    = 0;
  int failures  = 0;

  uart_tx_serializer_if tx_if ();

  uart_tx_serializer #(.IDLE_LEVEL(1'b1)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .baudSignalIn (baudSignalIn),
    .tx_if        (tx_if),
    .wordLength   (wordLength),
    .parityEnable (parityEnable),
    .evenParity   (evenParity),
    .twoStopBits  (twoStopBits),
    .breakCtrl    (breakCtrl),
    .txOut        (txOut),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always begin
    @(negedge clock);
    baud_cnt = baud_cnt + 1;
    if (baud_cnt >= baud_half) begin
      baudSignalIn = ~baudSignalIn;
      baud_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge
  task automatic send_byte(input logic [7:0] d, input bit keep_valid);
    int n;
    n = 0;
    tx_if.txData  = d;
    tx_if.txValid = 1'b1;
    while (tx_if.txReady !== 1'b1 && n < 4000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 4000) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clock);
    @(negedge clock);
    if (!keep_valid) tx_if.txValid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  // Expected frame = start, data LSB first, optional parity, stop bit(s);
  // one sample per bit taken mid-bit on the falling edge of the baud wave.
  task automatic expect_frame(input logic [7:0] d, input bit immediate,
                              input int brk_idx, input int dis_idx, input string tag);
    logic q[$];
    int   nb;
    int   ones;
    int   waited;
    nb   = 5 + int'(wordLength);
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (parityEnable) q.push_back(evenParity ? (ones % 2 == 1) : (ones % 2 == 0));
    q.push_back(1'b1);
    if (twoStopBits) q.push_back(1'b1);

    @(negedge baudSignalIn);
    waited = 0;
    if (!immediate) begin
      while (txOut !== 1'b0 && waited < 64) begin
        @(negedge baudSignalIn);
        waited++;
      end
    end
    check($sformatf("%s start", tag), txOut, 1'b0);
    for (int i = 1; i < q.size(); i++) begin
      breakCtrl = (i == brk_idx);
      if (i == dis_idx) enable = 1'b0;
      @(negedge baudSignalIn);
      check($sformatf("%s bit%0d", tag, i), txOut, (i == brk_idx) ? 1'b0 : q[i]);
    end
    breakCtrl = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    int         n;
    tx_if.txData  = 8'h00;
    tx_if.txValid = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_txOut", txOut, 1'b1);
    check("rst_busy", busy, 1'b0);
    enable = 1'b1;
    #1;
    check("rst_txReady", tx_if.txReady, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_rst_txReady", tx_if.txReady, 1'b1);
    @(negedge clock);

    // 8N1 0xA5, 32-clock bit time
    baud_half = 16;
    wordLength = 2'd3; parityEnable = 1'b0; twoStopBits = 1'b0;
    send_byte(8'hA5, 1'b0);
    check("a5_ready_low", tx_if.txReady, 1'b0);
    check("a5_busy", busy, 1'b1);
    n = 0;
    while (tx_if.txReady !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("a5_ready_rise", tx_if.txReady, 1'b1);
    expect_frame(8'hA5, 1'b0, -1, -1, "8N1_A5");
    wait_idle("a5_idle");
    @(negedge clock);

    // 7E2 0x35 (bit 7 ignored)
    baud_half = 8;
    wordLength = 2'd2; parityEnable = 1'b1; evenParity = 1'b1; twoStopBits = 1'b1;
    send_byte(8'hB5, 1'b0);
    expect_frame(8'hB5, 1'b0, -1, -1, "7E2_35");
    wait_idle("7e2_idle");
    @(negedge clock);

    // 5O1 / 5E1 0x1F
    wordLength = 2'd0; evenParity = 1'b0; twoStopBits = 1'b0;
    send_byte(8'h1F, 1'b0);
    expect_frame(8'h1F, 1'b0, -1, -1, "5O1_1F");
    wait_idle("5o1_idle");
    @(negedge clock);
    evenParity = 1'b1;
    send_byte(8'h1F, 1'b0);
    expect_frame(8'h1F, 1'b0, -1, -1, "5E1_1F");
    wait_idle("5e1_idle");
    @(negedge clock);

    // Back-to-back 0x55 then 0xAA with valid held high
    wordLength = 2'd3; parityEnable = 1'b0;
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b0);
    expect_frame(8'h55, 1'b0, -1, -1, "b2b_55");
    expect_frame(8'hAA, 1'b1, -1, -1, "b2b_AA");
    wait_idle("b2b_idle");
    @(negedge clock);

    // Break pulse during data bit 3 of an all-ones byte
    send_byte(8'hFF, 1'b0);
    expect_frame(8'hFF, 1'b0, 4, -1, "break");
    wait_idle("break_idle");
    @(negedge clock);

    // Disable mid-frame: frame finishes, held byte waits for enable
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b0);
    expect_frame(8'h5A, 1'b0, -1, 4, "dis_5A");
    repeat (8) @(negedge baudSignalIn);
    check("dis_line_idle", txOut, 1'b1);
    check("dis_busy", busy, 1'b1);
    check("dis_ready", tx_if.txReady, 1'b0);
    enable = 1'b1;
    expect_frame(8'hC3, 1'b0, -1, -1, "dis_C3");
    wait_idle("dis_idle");
    @(negedge clock);

    // Reset during the parity bit of a 7E1 frame with a byte held
    wordLength = 2'd2; parityEnable = 1'b1; evenParity = 1'b1; twoStopBits = 1'b0;
    send_byte(8'h6A, 1'b1);
    send_byte(8'h81, 1'b0);
    n = 0;
    @(negedge baudSignalIn);
    while (txOut !== 1'b0 && n < 64) begin
      @(negedge baudSignalIn);
      n++;
    end
    check("rstp_start", txOut, 1'b0);
    repeat (8) @(negedge baudSignalIn);
    check("rstp_parity", txOut, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("rstp_txOut", txOut, 1'b1);
    check("rstp_busy", busy, 1'b0);
    check("rstp_ready", tx_if.txReady, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge baudSignalIn);
    check("rstp_discard_line", txOut, 1'b1);
    check("rstp_discard_busy", busy, 1'b0);
    @(negedge clock);
    send_byte(8'h3C, 1'b0);
    expect_frame(8'h3C, 1'b0, -1, -1, "rstp_3C");
    wait_idle("rstp_idle");
    @(negedge clock);

    // Randomized bytes, formats and bit times
    for (int k = 0; k < 12; k++) begin
      rd           = 8'($urandom);
      wordLength   = 2'($urandom_range(0, 3));
      parityEnable = 1'($urandom_range(0, 1));
      evenParity   = 1'($urandom_range(0, 1));
      twoStopBits  = 1'($urandom_range(0, 1));
      baud_half    = int'($urandom_range(4, 12));
      send_byte(rd, 1'b0);
      expect_frame(rd, 1'b0, -1, -1, $sformatf("rnd%0d_%02h", k, rd));
      wait_idle($sformatf("rnd%0d_idle", k));
      @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
